// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART TX frame arbiter: FSM state encoding,
// default sync bytes and the running checksum helper.
package uart_frame_pkg;

    localparam int         IDX_W     = 3;
    localparam logic [7:0] SYNC0_DEF = 8'hAA;
    localparam logic [7:0] SYNC1_DEF = 8'h55;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S0,
        ST_S1,
        ST_ID,
        ST_LEN,
        ST_DATA,
        ST_CSUM
    } state_t;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/uart_tx_frame_arbiter_rr.sv
// Round-robin requester selection for the frame arbiter; holds only the search pointer,
// which moves to winner+1 when the top commits a grant.
module rr_arbiter
    import uart_frame_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] req,
    input  logic               advance,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               valid
);

    logic [IDX_W-1:0]   ptr_q;
    logic [NUM_SRC-1:0] req_sh;
    int                 cand;

    always_comb begin
        grant  = '0;
        index  = '0;
        valid  = 1'b0;
        cand   = 0;
        req_sh = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NUM_SRC) cand = cand - NUM_SRC;
            req_sh = req >> cand;
            if (!valid && req_sh[0]) begin
                valid = 1'b1;
                index = IDX_W'(cand);
                grant = NUM_SRC'(1) << cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (advance && valid) begin
            ptr_q <= (index == IDX_W'(NUM_SRC - 1)) ? '0 : index + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// Frames messages from NUM_SRC sources onto one UART TX byte FIFO, one whole frame per grant.
// Define UART_FRAME_CSUM_EN to append a two's-complement checksum byte to every frame.
//
// state   | meaning
// IDLE    | drop grant of finished frame, else arbitrate and latch winner + length
// S0      | issue SYNC0
// S1      | issue SYNC1
// ID      | issue source index
// LEN     | issue latched length, load payload down-counter
// DATA    | issue payload bytes, popping the granted source
// CSUM    | issue checksum (UART_FRAME_CSUM_EN only)
module uart_tx_frame_arbiter
    import uart_frame_pkg::*;
#(
    parameter int         NUM_SRC = 4,
    parameter logic [7:0] SYNC0   = SYNC0_DEF,
    parameter logic [7:0] SYNC1   = SYNC1_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_SRC-1:0]   src_req,
    input  logic [8*NUM_SRC-1:0] src_len,
    input  logic [8*NUM_SRC-1:0] src_data,
    output logic [NUM_SRC-1:0]   src_rd,
    output logic [NUM_SRC-1:0]   src_grant,
    output logic                 busy,
    input  logic                 tx_ready,
    output logic [7:0]           fifo_data8,
    output logic                 fifo_wrreq
);

`ifdef UART_FRAME_CSUM_EN
    localparam state_t TAIL_STATE = ST_CSUM;
`else
    localparam state_t TAIL_STATE = ST_IDLE;
`endif

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               gap_q, gap_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [NUM_SRC-1:0] rd_q, rd_d;
    logic               busy_q, busy_d;
    logic               wrreq_q, wrreq_d;
    logic [7:0]         data_q, data_d;
`ifdef UART_FRAME_CSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic [NUM_SRC-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic               advance;
    logic [7:0]         sel_data;
    logic [7:0]         arb_len;
    logic [7:0]         id_byte;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
        .clock   (clock),
        .reset   (reset),
        .req     (src_req),
        .advance (advance),
        .grant   (arb_grant),
        .index   (arb_idx),
        .valid   (arb_valid)
    );

    always_comb begin
        sel_data = '0;
        arb_len  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (idx_q == IDX_W'(i))   sel_data = src_data[8*i +: 8];
            if (arb_idx == IDX_W'(i)) arb_len  = src_len[8*i +: 8];
        end
    end

    assign id_byte = {{(8-IDX_W){1'b0}}, idx_q};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        gap_d   = 1'b0;
        grant_d = grant_q;
        rd_d    = '0;
        busy_d  = busy_q;
        wrreq_d = 1'b0;
        data_d  = data_q;
        advance = 1'b0;
`ifdef UART_FRAME_CSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // a finished frame spends one IDLE cycle releasing the grant, which
                // guarantees the idle gap before the next arbitration
                if (busy_q) begin
                    busy_d  = 1'b0;
                    grant_d = '0;
                end else if (arb_valid) begin
                    advance = 1'b1;
                    idx_d   = arb_idx;
                    len_d   = arb_len;
                    grant_d = arb_grant;
                    busy_d  = 1'b1;
                    state_d = ST_S0;
`ifdef UART_FRAME_CSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_S0: if (tx_ready) begin
                wrreq_d = 1'b1;
                data_d  = SYNC0;
                state_d = ST_S1;
            end
            ST_S1: if (tx_ready) begin
                wrreq_d = 1'b1;
                data_d  = SYNC1;
                state_d = ST_ID;
            end
            ST_ID: if (tx_ready) begin
                wrreq_d = 1'b1;
                data_d  = id_byte;
                state_d = ST_LEN;
`ifdef UART_FRAME_CSUM_EN
                csum_d  = csum_update(csum_q, id_byte);
`endif
            end
            ST_LEN: if (tx_ready) begin
                wrreq_d = 1'b1;
                data_d  = len_q;
                cnt_d   = len_q;
                state_d = (len_q == 8'd0) ? TAIL_STATE : ST_DATA;
`ifdef UART_FRAME_CSUM_EN
                csum_d  = csum_update(csum_q, len_q);
`endif
            end
            ST_DATA: begin
                // skip one cycle after each pop so the source can present its next byte
                if (tx_ready && !gap_q) begin
                    wrreq_d = 1'b1;
                    data_d  = sel_data;
                    rd_d    = grant_q;
                    gap_d   = 1'b1;
                    cnt_d   = cnt_q - 8'd1;
                    state_d = (cnt_q == 8'd1) ? TAIL_STATE : ST_DATA;
`ifdef UART_FRAME_CSUM_EN
                    csum_d  = csum_update(csum_q, sel_data);
`endif
                end
            end
`ifdef UART_FRAME_CSUM_EN
            ST_CSUM: if (tx_ready) begin
                wrreq_d = 1'b1;
                data_d  = 8'h00 - csum_q;
                state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= 1'b0;
            grant_q <= '0;
            rd_q    <= '0;
            busy_q  <= 1'b0;
            wrreq_q <= 1'b0;
            data_q  <= '0;
`ifdef UART_FRAME_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            grant_q <= grant_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            wrreq_q <= wrreq_d;
            data_q  <= data_d;
`ifdef UART_FRAME_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign src_rd     = rd_q;
    assign src_grant  = grant_q;
    assign busy       = busy_q;
    assign fifo_wrreq = wrreq_q;
    assign fifo_data8 = data_q;

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Directed bench for uart_tx_frame_arbiter: framing, round-robin order, stalls,
// zero-length frames, reset mid-frame and request drop mid-frame.
module tb_uart_tx_frame_arbiter;

    localparam int N = 4;
`ifdef UART_FRAME_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   src_req = '0;
    logic [8*N-1:0] src_len = '0;
    logic [8*N-1:0] src_data;
    logic [N-1:0]   src_rd;
    logic [N-1:0]   src_grant;
    logic           busy;
    logic           tx_ready = 1'b1;
    logic [7:0]     fifo_data8;
    logic           fifo_wrreq;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    uart_tx_frame_arbiter #(.NUM_SRC(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .src_req    (src_req),
        .src_len    (src_len),
        .src_data   (src_data),
        .src_rd     (src_rd),
        .src_grant  (src_grant),
        .busy       (busy),
        .tx_ready   (tx_ready),
        .fifo_data8 (fifo_data8),
        .fifo_wrreq (fifo_wrreq)
    );

    // show-ahead source model: each source pops on its src_rd strobe
    logic [7:0] mem [N][64];
    logic [5:0] rd_ptr [N] = '{default: 6'd0};

    always_comb begin
        src_data = '0;
        for (int i = 0; i < N; i++) src_data[8*i +: 8] = mem[i][rd_ptr[i]];
    end

    logic toggle_rdy = 1'b0;
    always @(negedge clock) tx_ready = toggle_rdy ? ~tx_ready : 1'b1;

    // monitor: byte log, grant log, read counts and protocol violations
    logic [7:0]   got[$];
    logic [N-1:0] grant_log[$];
    int           rd_cnt [N] = '{default: 0};
    int           viol = 0;
    logic         rdy_edge = 1'b1;
    logic [N-1:0] prev_grant = '0;

    always @(posedge clock) begin
        rdy_edge <= tx_ready;
        for (int i = 0; i < N; i++) if (src_rd[i]) rd_ptr[i] <= rd_ptr[i] + 6'd1;
    end

    always @(negedge clock) begin
        if (fifo_wrreq) begin
            got.push_back(fifo_data8);
            if (!rdy_edge) viol++;
        end
        if (!$onehot0(src_grant)) viol++;
        if (busy !== (|src_grant)) viol++;
        if ((src_rd & ~src_grant) != '0) viol++;
        if (src_grant != '0 && prev_grant != '0 && src_grant != prev_grant) viol++;
        if (src_grant != '0 && prev_grant == '0) grant_log.push_back(src_grant);
        for (int i = 0; i < N; i++) if (src_rd[i]) rd_cnt[i]++;
        prev_grant = src_grant;
    end

    logic [7:0] exp_q[$];

    task automatic build_exp(input int src, input int len, input int base);
        logic [7:0] sum;
        logic [7:0] b;
        exp_q.delete();
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        exp_q.push_back(8'(src));
        exp_q.push_back(8'(len));
        sum = 8'(src) + 8'(len);
        for (int k = 0; k < len; k++) begin
            b = mem[src][6'(base + k)];
            exp_q.push_back(b);
            sum = sum + b;
        end
        if (CS == 1) exp_q.push_back(8'h00 - sum);
    endtask

    task automatic load_src(input int src, input int len, input logic [7:0] seed);
        for (int k = 0; k < len; k++) mem[src][6'(int'(rd_ptr[src]) + k)] = seed + 8'(k * 17);
        src_len[8*src +: 8] = 8'(len);
    endtask

    task automatic run_frame(input int src, input int hold, output int lat, output bit ok);
        int n;
        ok  = 1'b1;
        lat = -1;
        src_req[src] = 1'b1;
        n = 0;
        while (src_grant == '0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (src_grant == '0) begin
            src_req[src] = 1'b0;
            ok = 1'b0;
            return;
        end
        if (hold == 0) src_req[src] = 1'b0;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clock);
            n++;
            if (n == hold) src_req[src] = 1'b0;
            if (fifo_wrreq && lat < 0) lat = n;
        end
        src_req[src] = 1'b0;
        if (busy) ok = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        src_req = '0;
        repeat (3) @(negedge clock);
        checks++; if (src_grant !== '0) begin errors++; $display("FAIL reset_grant: got %b expected 0", src_grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (fifo_wrreq !== 1'b0) begin errors++; $display("FAIL reset_wrreq: got %b expected 0", fifo_wrreq); end
        checks++; if (fifo_data8 !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", fifo_data8); end
        checks++; if (src_rd !== '0) begin errors++; $display("FAIL reset_rd: got %b expected 0", src_rd); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_round_robin();
        int g0, b0, v0, frames, n, fl;
        logic pb;
        logic [N-1:0] exp_g [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        fl = 5 + CS;
        g0 = grant_log.size(); b0 = got.size(); v0 = viol;
        for (int i = 0; i < N; i++) load_src(i, 1, 8'(8'h30 + 16 * i));
        mem[0][6'(int'(rd_ptr[0]) + 1)] = 8'h3F;
        src_req = '1;
        frames = 0; n = 0; pb = busy;
        while (frames < 5 && n < 1000) begin
            @(negedge clock);
            n++;
            if (pb && !busy) frames++;
            pb = busy;
        end
        src_req = '0;
        repeat (10) @(negedge clock);
        checks++; if (frames != 5) begin errors++; $display("FAIL rr_frames: got %0d expected 5", frames); end
        checks++;
        if (grant_log.size() - g0 != 5) begin
            errors++; $display("FAIL rr_grant_count: got %0d expected 5", grant_log.size() - g0);
        end else begin
            for (int f = 0; f < 5; f++) begin
                checks++;
                if (grant_log[g0 + f] !== exp_g[f]) begin
                    errors++; $display("FAIL rr_grant_order[%0d]: got %b expected %b", f, grant_log[g0 + f], exp_g[f]);
                end
            end
        end
        checks++;
        if (got.size() - b0 != 5 * fl) begin
            errors++; $display("FAIL rr_byte_count: got %0d expected %0d", got.size() - b0, 5 * fl);
        end else begin
            for (int f = 0; f < 5; f++) begin
                checks++;
                if (got[b0 + f * fl + 2] !== 8'(f % 4)) begin
                    errors++; $display("FAIL rr_id[%0d]: got %h expected %h", f, got[b0 + f * fl + 2], 8'(f % 4));
                end
            end
            checks++;
            if (got[b0 + 4 * fl + 4] !== 8'h3F) begin
                errors++; $display("FAIL rr_second_pop: got %h expected 3f", got[b0 + 4 * fl + 4]);
            end
        end
        checks++; if (viol != v0) begin errors++; $display("FAIL rr_protocol: got %0d violations expected 0", viol - v0); end
    endtask

    task automatic test_single();
        int b0, r0, v0, base, lat;
        bit ok;
        base = int'(rd_ptr[0]);
        mem[0][6'(base)] = 8'h11; mem[0][6'(base + 1)] = 8'h22; mem[0][6'(base + 2)] = 8'h33;
        src_len[7:0] = 8'd3;
        b0 = got.size(); r0 = rd_cnt[0]; v0 = viol;
        run_frame(0, 0, lat, ok);
        build_exp(0, 3, base);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d expected 1", ok); end
        checks++; if (lat != 1) begin errors++; $display("FAIL single_latency: got %0d expected 1", lat); end
        checks++;
        if (got.size() - b0 != exp_q.size()) begin
            errors++; $display("FAIL single_len: got %0d expected %0d", got.size() - b0, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (got[b0 + k] !== exp_q[k]) begin
                    errors++; $display("FAIL single_byte[%0d]: got %h expected %h", k, got[b0 + k], exp_q[k]);
                end
            end
        end
        checks++; if (rd_cnt[0] - r0 != 3) begin errors++; $display("FAIL single_rd: got %0d expected 3", rd_cnt[0] - r0); end
        checks++; if (viol != v0) begin errors++; $display("FAIL single_protocol: got %0d expected 0", viol - v0); end
    endtask

    task automatic test_stall();
        int b0, r0, v0, base, lat;
        bit ok;
        base = int'(rd_ptr[3]);
        load_src(3, 5, 8'h51);
        b0 = got.size(); r0 = rd_cnt[3]; v0 = viol;
        toggle_rdy = 1'b1;
        run_frame(3, 0, lat, ok);
        toggle_rdy = 1'b0;
        build_exp(3, 5, base);
        checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: got %0d expected 1", ok); end
        checks++;
        if (got.size() - b0 != exp_q.size()) begin
            errors++; $display("FAIL stall_len: got %0d expected %0d", got.size() - b0, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (got[b0 + k] !== exp_q[k]) begin
                    errors++; $display("FAIL stall_byte[%0d]: got %h expected %h", k, got[b0 + k], exp_q[k]);
                end
            end
        end
        checks++; if (rd_cnt[3] - r0 != 5) begin errors++; $display("FAIL stall_rd: got %0d expected 5", rd_cnt[3] - r0); end
        checks++; if (viol != v0) begin errors++; $display("FAIL stall_wr_without_ready: got %0d expected 0", viol - v0); end
    endtask

    task automatic test_zero_len();
        int b0, r0, lat;
        bit ok;
        src_len[23:16] = 8'd0;
        b0 = got.size(); r0 = rd_cnt[2];
        run_frame(2, 0, lat, ok);
        build_exp(2, 0, 0);
        checks++; if (!ok) begin errors++; $display("FAIL zero_timeout: got %0d expected 1", ok); end
        checks++;
        if (got.size() - b0 != exp_q.size()) begin
            errors++; $display("FAIL zero_len: got %0d expected %0d", got.size() - b0, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (got[b0 + k] !== exp_q[k]) begin
                    errors++; $display("FAIL zero_byte[%0d]: got %h expected %h", k, got[b0 + k], exp_q[k]);
                end
            end
        end
        checks++; if (rd_cnt[2] != r0) begin errors++; $display("FAIL zero_rd: got %0d expected 0", rd_cnt[2] - r0); end
    endtask

    task automatic test_drop_req();
        int b0, r0, g0, base, lat;
        bit ok;
        base = int'(rd_ptr[1]);
        load_src(1, 3, 8'h71);
        b0 = got.size(); r0 = rd_cnt[1]; g0 = grant_log.size();
        run_frame(1, 3, lat, ok);
        repeat (20) @(negedge clock);
        build_exp(1, 3, base);
        checks++; if (!ok) begin errors++; $display("FAIL drop_timeout: got %0d expected 1", ok); end
        checks++;
        if (got.size() - b0 != exp_q.size()) begin
            errors++; $display("FAIL drop_len: got %0d expected %0d", got.size() - b0, exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (got[b0 + k] !== exp_q[k]) begin
                    errors++; $display("FAIL drop_byte[%0d]: got %h expected %h", k, got[b0 + k], exp_q[k]);
                end
            end
        end
        checks++; if (rd_cnt[1] - r0 != 3) begin errors++; $display("FAIL drop_rd: got %0d expected 3", rd_cnt[1] - r0); end
        checks++; if (grant_log.size() - g0 != 1) begin errors++; $display("FAIL drop_regrant: got %0d grants expected 1", grant_log.size() - g0); end
    endtask

    task automatic test_reset_mid();
        int b0, n;
        load_src(1, 4, 8'h91);
        b0 = got.size();
        src_req[1] = 1'b1;
        n = 0;
        while (src_grant == '0 && n < 200) begin @(negedge clock); n++; end
        src_req[1] = 1'b0;
        n = 0;
        while (got.size() < b0 + 6 && n < 200) begin @(negedge clock); n++; end
        checks++; if (got.size() < b0 + 6) begin errors++; $display("FAIL midrst_reach_data: got %0d bytes expected 6", got.size() - b0); end
        reset = 1'b1;
        src_req = 4'b0101;
        @(negedge clock);
        checks++; if (src_grant !== '0) begin errors++; $display("FAIL midrst_grant: got %b expected 0", src_grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (fifo_wrreq !== 1'b0) begin errors++; $display("FAIL midrst_wrreq: got %b expected 0", fifo_wrreq); end
        checks++; if (fifo_data8 !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h expected 00", fifo_data8); end
        checks++; if (src_rd !== '0) begin errors++; $display("FAIL midrst_rd: got %b expected 0", src_rd); end
        reset = 1'b0;
        n = 0;
        while (src_grant == '0 && n < 50) begin @(negedge clock); n++; end
        checks++; if (src_grant !== 4'b0001) begin errors++; $display("FAIL midrst_first_grant: got %b expected 0001", src_grant); end
        src_req = '0;
        n = 0;
        while (busy && n < 400) begin @(negedge clock); n++; end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_finish: got %b expected 0", busy); end
        repeat (5) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_stall();
        test_zero_len();
        test_drop_req();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
